zfifo_rd: RTL and testbench

- Bus slave FIFO that sits directly downstream of the PS-to-PL bus master on the shared 16-bit "bus" (baddr/bwr/bstrobe/bwrdata/brddata).
- PL logic pushes 16-bit words in through a valid/ready stream.
- The PS drains words through ordinary bus reads, one pop per bstrobe.
- Bus writes to the data address also push words, for loopback testing.
- Status and control registers share a 3-word address window.

---
 rtl/zfifo_rd.sv | 219 +++++++++++++++++++++
 tb/tb_zfifo_rd.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zfifo_rd.sv
// zfifo_rd: PL-to-PS FIFO that sits on the shared 16-bit bus as a slave.
//
// PL logic pushes words through a valid/ready stream; the PS drains them with
// bus reads of MYADDR+0, one pop per bstrobe. Bus writes to MYADDR+0 also push
// (loopback). MYADDR+1 is a read-only status word, MYADDR+2 holds the pop
// counter and takes control writes (bit0 flush, bit1 clear flags, bit2 clear
// pop counter).
//
// Ports:
//   clk       bus clock, all state on posedge
//   reset     asynchronous active-high reset; release is expected to be
//             synchronous to clk
//   baddr     bus address
//   bwr       bus write qualifier
//   bstrobe   one-cycle strobe, 2nd cycle of each bus operation
//   bwrdata   bus write data
//   brddata   bus read data, high-Z outside the 3-word window
//   in_valid  upstream word valid
//   in_data   upstream word
//   in_ready  FIFO accepts in_data this cycle (combinational)
//   nonempty  occupancy is nonzero
//   count     current occupancy, 0 .. 2**DEPTH_LOG2
module zfifo_rd #(
    parameter logic [15:0] MYADDR     = 16'h0010,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           baddr,
    input  logic                  bwr,
    input  logic                  bstrobe,
    input  logic [15:0]           bwrdata,
    output logic [15:0]           brddata,
    input  logic                  in_valid,
    input  logic [15:0]           in_data,
    output logic                  in_ready,
    output logic                  nonempty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SW    = 12;   // width of count field in status

    // Word offsets inside the register window
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_CTRL = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr,  wr_ptr_d;
    logic [AW-1:0] rd_ptr,  rd_ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          ovf_q,   ovf_d;
    logic          unf_q,   unf_d;
    logic [15:0]   npop_q,  npop_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [15:0] offset;
    logic        addr_hit;
    logic        sel_data;
    logic        sel_ctrl;

    // Subtracting the base keeps the window correct even when MYADDR+2 wraps.
    assign offset   = baddr - MYADDR;
    assign addr_hit = (offset < 16'd3);
    assign sel_data = addr_hit && (offset[1:0] == OFF_DATA);
    assign sel_ctrl = addr_hit && (offset[1:0] == OFF_CTRL);

    // ------------------------------------------------------------------
    // Occupancy flags
    // ------------------------------------------------------------------
    logic full;
    logic empty;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // ------------------------------------------------------------------
    // Bus and stream events
    // ------------------------------------------------------------------
    logic bus_pop;
    logic bus_push;
    logic ctrl_wr;
    logic flush;
    logic stream_push;
    logic push_req;
    logic push_ok;
    logic pop_ok;
    logic [15:0] wr_word;

    assign bus_pop  = bstrobe && !bwr && sel_data;
    assign bus_push = bstrobe &&  bwr && sel_data;
    assign ctrl_wr  = bstrobe &&  bwr && sel_ctrl;
    assign flush    = ctrl_wr && bwrdata[0];

    // The bus owns the single write port in a bus-push cycle, so the stream
    // is stalled rather than dropped.
    assign in_ready    = !full && !bus_push && !flush;
    assign stream_push = in_valid && in_ready;

    assign push_req = bus_push || stream_push;
    assign push_ok  = push_req && !full && !flush;
    assign pop_ok   = bus_pop && !empty && !flush;
    assign wr_word  = bus_push ? bwrdata : in_data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        npop_d   = npop_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        if (pop_ok) begin
            npop_d = npop_q + 16'd1;
        end

        // A bus push into a full FIFO is dropped even if a pop lands too
        if (bus_push && full && !flush) begin
            ovf_d = 1'b1;
        end
        if (bus_pop && empty && !flush) begin
            unf_d = 1'b1;
        end

        // Clears are applied last so they win over a same-cycle set
        if (ctrl_wr && bwrdata[1]) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ctrl_wr && bwrdata[2]) begin
            npop_d = 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            npop_q <= 16'h0000;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            npop_q <= npop_d;
        end
    end

    // Distributed RAM: synchronous write, asynchronous read, not reset
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [15:0] status_word;
    logic [15:0] rd_mux;

    assign status_word = {full, empty, ovf_q, unf_q, SW'(cnt_q)};

    always_comb begin
        rd_mux = 16'h0000;
        case (offset[1:0])
            OFF_DATA: rd_mux = empty ? 16'h0000 : mem[rd_ptr];
            OFF_STAT: rd_mux = status_word;
            OFF_CTRL: rd_mux = npop_q;
            default:  rd_mux = 16'h0000;
        endcase
    end

    assign brddata = addr_hit ? rd_mux : 16'hzzzz;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count    = cnt_q;
    assign nonempty = !empty;

endmodule

// File: tb/tb_zfifo_rd.sv
// Testbench for zfifo_rd: table of hand-derived bus/stream cycles, directed
// fill/overflow/reset sequences, then random traffic against a queue model.
module tb_zfifo_rd;

    localparam logic [15:0] BASE  = 16'h0010;
    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = DL + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   baddr = 16'h0000;
    logic          bwr = 1'b0;
    logic          bstrobe = 1'b0;
    logic [15:0]   bwrdata = 16'h0000;
    logic [15:0]   brddata;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = 16'h0000;
    logic          in_ready;
    logic          nonempty;
    logic [CW-1:0] count;

    zfifo_rd #(.MYADDR(BASE), .DEPTH_LOG2(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .baddr    (baddr),
        .bwr      (bwr),
        .bstrobe  (bstrobe),
        .bwrdata  (bwrdata),
        .brddata  (brddata),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .nonempty (nonempty),
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive just after the edge, leave time to settle.
    task automatic cyc(input logic [15:0] a, input logic w, input logic s,
                       input logic [15:0] wd, input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        baddr = a; bwr = w; bstrobe = s; bwrdata = wd; in_valid = v; in_data = d;
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        baddr = 16'h0000; bwr = 1'b0; bstrobe = 1'b0; bwrdata = 16'h0000;
        in_valid = 1'b0; in_data = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_npop;

    function automatic void model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_npop = 16'h0000;
    endfunction

    function automatic logic m_ready(input logic [15:0] a, input logic w, input logic s,
                                     input logic [15:0] wd);
        logic bpush, flsh;
        bpush = s && w && (a == BASE);
        flsh  = s && w && (a == BASE + 16'd2) && wd[0];
        return (mq.size() != DEPTH) && !bpush && !flsh;
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        logic [15:0] r;
        r = 16'h0000;
        if (a == BASE)
            r = (mq.size() != 0) ? mq[0] : 16'h0000;
        else if (a == BASE + 16'd1)
            r = {mq.size() == DEPTH, mq.size() == 0, m_ovf, m_unf, 12'(mq.size())};
        else if (a == BASE + 16'd2)
            r = m_npop;
        return r;
    endfunction

    function automatic void model_step(input logic [15:0] a, input logic w, input logic s,
                                       input logic [15:0] wd, input logic acc,
                                       input logic [15:0] d);
        logic bpush, bpop, ctl;
        int sz;
        bpush = s &&  w && (a == BASE);
        bpop  = s && !w && (a == BASE);
        ctl   = s &&  w && (a == BASE + 16'd2);
        sz    = mq.size();
        if (ctl && wd[0]) begin
            mq.delete();
        end else begin
            if (bpop) begin
                if (sz == 0) m_unf = 1'b1;
                else begin
                    void'(mq.pop_front());
                    m_npop = m_npop + 16'd1;
                end
            end
            if (bpush) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else mq.push_back(wd);
            end else if (acc) begin
                mq.push_back(d);
            end
        end
        if (ctl && wd[1]) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ctl && wd[2]) m_npop = 16'h0000;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] a;
        logic        w;
        logic        s;
        logic [15:0] wd;
        logic        v;
        logic [15:0] d;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_rdy;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [15:0] a, input logic w, input logic s,
                                input logic [15:0] wd, input logic v, input logic [15:0] d,
                                input logic c, input logic [15:0] er, input logic ey,
                                input int ec);
        vec_t t;
        t.a = a; t.w = w; t.s = s; t.wd = wd; t.v = v; t.d = d;
        t.chk_rd = c; t.exp_rd = er; t.exp_rdy = ey; t.exp_cnt = ec;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rdv;
        int k;
        logic acc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_nonempty", 32'(nonempty), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        #1 reset = 1'b0;

        // Empty reads, underflow, stream 3 words, pops, control, collision, flush
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 0));
        tbl.push_back(mk(16'h0011, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 0));
        tbl.push_back(mk(16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0010, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h5000, 1, 0));
        tbl.push_back(mk(16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 16'h2222, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 16'h3333, 0, 16'h0000, 1, 2));
        tbl.push_back(mk(16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1111, 1, 3));
        tbl.push_back(mk(16'h0010, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h1111, 1, 3));
        tbl.push_back(mk(16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h2222, 1, 2));
        tbl.push_back(mk(16'h0010, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h2222, 1, 2));
        tbl.push_back(mk(16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3333, 1, 1));
        tbl.push_back(mk(16'h0010, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h3333, 1, 1));
        tbl.push_back(mk(16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 1, 0));
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h5000, 1, 0));
        tbl.push_back(mk(16'h0012, 1, 0, 16'h0006, 0, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0012, 1, 1, 16'h0006, 0, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 0));
        tbl.push_back(mk(16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0010, 1, 0, 16'habcd, 0, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0010, 1, 1, 16'habcd, 1, 16'h5555, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 16'h5555, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'habcd, 1, 2));
        tbl.push_back(mk(16'h0010, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'habcd, 1, 2));
        tbl.push_back(mk(16'h0010, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h5555, 1, 1));
        tbl.push_back(mk(16'h0010, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h5555, 1, 1));
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 0));
        tbl.push_back(mk(16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 0));
        tbl.push_back(mk(16'h0000, 0, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0012, 1, 0, 16'h0005, 1, 16'h8888, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(16'h0012, 1, 1, 16'h0005, 1, 16'h9999, 0, 16'h0000, 0, 2));
        tbl.push_back(mk(16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 0));
        tbl.push_back(mk(16'h0011, 1, 0, 16'hffff, 0, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0011, 1, 1, 16'hffff, 0, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 0));
        tbl.push_back(mk(16'h0011, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].wd, tbl[i].v, tbl[i].d);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), 32'(brddata), 32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
        end

        // Fill with in_valid held high: 16 accepted out of 20 offered
        do_reset();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(16'h0000, 0, 0, 16'h0000, 1, 16'h0100 + 16'(k));
            if (in_ready) k++;
        end
        chk("fill_accepted", 32'(k), 16);
        cyc(BASE + 16'd1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("fill_status", 32'(brddata), 32'h8010);
        chk("fill_ready", 32'(in_ready), 0);
        cyc(BASE, 0, 0, 16'h0000, 0, 16'h0000);
        chk("fill_head", 32'(brddata), 32'h0100);
        cyc(BASE, 0, 1, 16'h0000, 0, 16'h0000);
        chk("pop_cycle_ready", 32'(in_ready), 0);
        cyc(16'h0000, 0, 0, 16'h0000, 1, 16'h0110);
        chk("ready_after_pop", 32'(in_ready), 1);
        chk("count_after_pop", 32'(count), 15);
        cyc(16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        chk("refill_count", 32'(count), 16);

        // Overflow on bus push, then clear flags
        cyc(BASE, 1, 0, 16'hbeef, 0, 16'h0000);
        cyc(BASE, 1, 1, 16'hbeef, 0, 16'h0000);
        cyc(BASE + 16'd1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("ovf_status", 32'(brddata), 32'ha010);
        cyc(BASE + 16'd2, 1, 0, 16'h0002, 0, 16'h0000);
        cyc(BASE + 16'd2, 1, 1, 16'h0002, 0, 16'h0000);
        cyc(BASE + 16'd1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("clr_status", 32'(brddata), 32'h8010);

        // Drain: words 1..16 in order, the dropped beef never appears
        for (int j = 1; j <= 16; j++) begin
            cyc(BASE, 0, 0, 16'h0000, 0, 16'h0000);
            chk($sformatf("drain%0d", j), 32'(brddata), 32'(16'h0100 + 16'(j)));
            cyc(BASE, 0, 1, 16'h0000, 0, 16'h0000);
        end
        cyc(BASE + 16'd1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("drain_status", 32'(brddata), 32'h4000);

        // Async reset in the middle of a pop
        cyc(16'h0000, 0, 0, 16'h0000, 1, 16'h1234);
        cyc(16'h0000, 0, 0, 16'h0000, 1, 16'h5678);
        cyc(BASE, 0, 0, 16'h0000, 0, 16'h0000);
        chk("pre_rst_head", 32'(brddata), 32'h1234);
        @(posedge clk);
        #1 bstrobe = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_rd", 32'(brddata), 32'h0000);
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_nonempty", 32'(nonempty), 0);
        chk("rst_mid_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 bstrobe = 1'b0;
        reset = 1'b0;
        cyc(BASE + 16'd1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("post_rst_status", 32'(brddata), 32'h4000);
        cyc(BASE + 16'd2, 0, 0, 16'h0000, 0, 16'h0000);
        chk("post_rst_npop", 32'(brddata), 32'h0000);

        // Random traffic against the queue model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a, wd, d;
            logic w, s, v;
            int r;
            r = int'($urandom_range(0, 7));
            case (r)
                0, 1, 2: a = BASE;
                3:       a = BASE + 16'd1;
                4:       a = BASE + 16'd2;
                5:       a = BASE + 16'd3;
                default: a = 16'h0000;
            endcase
            w  = 1'($urandom_range(0, 1));
            s  = ($urandom_range(0, 2) == 0);
            wd = 16'($urandom);
            if (a == BASE + 16'd2 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
            v  = ((i / 300) % 2 == 1) ? ($urandom_range(0, 9) != 0)
                                       : ($urandom_range(0, 4) == 0);
            d  = 16'($urandom);
            cyc(a, w, s, wd, v, d);
            acc = v && m_ready(a, w, s, wd);
            chk("rnd_ready", 32'(in_ready), 32'(m_ready(a, w, s, wd)));
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_nonempty", 32'(nonempty), 32'(mq.size() != 0));
            if (a == BASE || a == BASE + 16'd1 || a == BASE + 16'd2) begin
                rdv = m_rd(a);
                chk("rnd_rd", 32'(brddata), 32'(rdv));
            end
            model_step(a, w, s, wd, acc, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
